// File: rtl/demux8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux8_pkg
// Brief    : Shared widths and holding-register state encoding for demux8_deser.
// Revision : 1.0
// ============================================================================
package demux8_pkg;

    localparam int BYTE_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [0:0] {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

endpackage : demux8_pkg
`default_nettype wire

// File: rtl/demux1_8.sv
`default_nettype none
// ============================================================================
// Module   : demux1_8
// Brief    : Combinational 1:8 demux, the inverse of the 8:1 serializer mux.
// Revision : 1.0
// ============================================================================
module demux1_8
    import demux8_pkg::*;
(
    input  logic [SEL_W-1:0]  Sel,
    input  logic              D,
    input  logic              en,
    output logic [BYTE_W-1:0] Y
);

    always_comb begin
        Y      = '0;
        Y[Sel] = D & en;
    end

endmodule : demux1_8
`default_nettype wire

// File: rtl/demux8_deser.sv
`default_nettype none
// ============================================================================
// Module   : demux8_deser
// Brief    : Serial-to-parallel receiver with one-entry valid/ready output
//            holding register and sticky overflow flag.
// Revision : 1.0
// ============================================================================
module demux8_deser
    import demux8_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              frame_sync,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  bit_idx,
    output logic              overflow,
    input  logic              ovf_clear
);

    logic [BYTE_W-1:0] col_q, col_d;
    logic [SEL_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d;
    hold_state_e       state_q, state_d;

    logic [SEL_W-1:0]  w_cnt_eff;
    logic [SEL_W-1:0]  w_pos;
    logic [BYTE_W-1:0] w_we;
    logic              w_complete;
    logic              w_load;
    logic              w_drop;

    // frame_sync restarts the byte, so a bit accepted alongside it lands at slot 0
    assign w_cnt_eff  = frame_sync ? '0 : cnt_q;
    assign w_pos      = MSB_FIRST ? ~w_cnt_eff : w_cnt_eff;
    assign w_complete = bit_valid && (w_cnt_eff == 3'd7);

    demux1_8 u_we_dec (
        .Sel (w_pos),
        .D   (1'b1),
        .en  (bit_valid),
        .Y   (w_we)
    );

    always_comb begin
        col_d = (col_q & ~w_we) | (w_we & {BYTE_W{bit_in}});
        cnt_d = w_cnt_eff;
        if (bit_valid) begin
            cnt_d = w_cnt_eff + 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        w_load  = 1'b0;
        w_drop  = 1'b0;
        case (state_q)
            HOLD_EMPTY: begin
                if (w_complete) begin
                    w_load  = 1'b1;
                    state_d = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                if (w_complete) begin
                    if (out_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (out_ready) begin
                    state_d = HOLD_EMPTY;
                end
            end
            default: state_d = HOLD_EMPTY;
        endcase
    end

    always_comb begin
        data_d = w_load ? col_d : data_q;
        ovf_d  = ovf_q;
        if (w_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            state_q <= HOLD_EMPTY;
        end else begin
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == HOLD_FULL);
    assign bit_idx   = cnt_q;
    assign overflow  = ovf_q;

endmodule : demux8_deser
`default_nettype wire

// File: tb/tb_demux8_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux8_deser
// Brief    : Self-checking bench driving LSB-first and MSB-first instances.
// Revision : 1.0
// ============================================================================
module tb_demux8_deser;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       frame_sync;
    logic       out_ready;
    logic       ovf_clear;

    logic [7:0] od_l, od_m;
    logic       ov_l, ov_m;
    logic [2:0] bi_l, bi_m;
    logic       of_l, of_m;

    int         vecs = 0;
    int         errs = 0;
    int         nvalid = 0;

    // reference model state
    bit         bq[$];
    logic       m_valid;
    logic       m_ovf;
    logic [7:0] m_dl;
    logic [7:0] m_dm;

    demux8_deser #(.MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .frame_sync (frame_sync),
        .out_data   (od_l),
        .out_valid  (ov_l),
        .out_ready  (out_ready),
        .bit_idx    (bi_l),
        .overflow   (of_l),
        .ovf_clear  (ovf_clear)
    );

    demux8_deser #(.MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .frame_sync (frame_sync),
        .out_data   (od_m),
        .out_valid  (ov_m),
        .out_ready  (out_ready),
        .bit_idx    (bi_m),
        .overflow   (of_m),
        .ovf_clear  (ovf_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic fs, input logic bv,
                                input logic b, input logic rdy, input logic clr);
        logic       comp;
        logic       drop;
        logic [7:0] nl;
        logic [7:0] nm;
        comp = 1'b0;
        drop = 1'b0;
        nl   = 8'h00;
        nm   = 8'h00;
        if (r) begin
            bq.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_dl    = 8'h00;
            m_dm    = 8'h00;
        end else begin
            if (fs) bq.delete();
            if (bv) begin
                bq.push_back(b);
                if (bq.size() == 8) begin
                    comp = 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        nl[i]     = bq[i];
                        nm[7 - i] = bq[i];
                    end
                    bq.delete();
                end
            end
            if (comp) begin
                if (!m_valid || rdy) begin
                    m_valid = 1'b1;
                    m_dl    = nl;
                    m_dm    = nm;
                end else begin
                    drop = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic fs, input logic bv,
                        input logic b, input logic rdy, input logic clr);
        rst        = r;
        frame_sync = fs;
        bit_valid  = bv;
        bit_in     = b;
        out_ready  = rdy;
        ovf_clear  = clr;
        @(posedge clk);
        model_update(r, fs, bv, b, rdy, clr);
        #1;
        if (ov_l) nvalid++;
        chk("data_lsb",  od_l,          m_dl);
        chk("data_msb",  od_m,          m_dm);
        chk("valid_lsb", {7'd0, ov_l},  {7'd0, m_valid});
        chk("valid_msb", {7'd0, ov_m},  {7'd0, m_valid});
        chk("idx_lsb",   {5'd0, bi_l},  8'(bq.size()));
        chk("idx_msb",   {5'd0, bi_m},  8'(bq.size()));
        chk("ovf_lsb",   {7'd0, of_l},  {7'd0, m_ovf});
        chk("ovf_msb",   {7'd0, of_m},  {7'd0, m_ovf});
    endtask

    // n bits of v, bit 0 first, on consecutive cycles
    task automatic send_bits(input logic [7:0] v, input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b1, v[i], rdy, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0;
        frame_sync = 1'b0; out_ready = 1'b0; ovf_clear = 1'b0;

        // reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_data",  od_l, 8'h00);
        chk("rst_valid", {7'd0, ov_l}, 8'h00);
        chk("rst_idx",   {5'd0, bi_l}, 8'h00);
        chk("rst_ovf",   {7'd0, of_l}, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // bit sequence 1,0,1,0,0,1,0,1 reads as A5 in both orders
        send_bits(8'hA5, 8, 1'b1);
        chk("a5_lsb", od_l, 8'hA5);
        chk("a5_msb", od_m, 8'hA5);
        chk("a5_valid", {7'd0, ov_l}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("a5_drop_valid", {7'd0, ov_l}, 8'h00);

        // 1,1,0,0,0,0,0,0
        send_bits(8'h03, 8, 1'b1);
        chk("c0_msb", od_m, 8'hC0);
        chk("c0_lsb", od_l, 8'h03);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // back-to-back with consumer stalled
        send_bits(8'h3C, 8, 1'b0);
        send_bits(8'hF0, 8, 1'b0);
        chk("stall_hold", od_l, 8'h3C);
        chk("stall_ovf",  {7'd0, of_l}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_clear",  {7'd0, of_l}, 8'h00);
        chk("still_full", {7'd0, ov_l}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // resync mid-byte
        send_bits(8'h1F, 5, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("resync_idx", {5'd0, bi_l}, 8'h01);
        send_bits(8'h00, 7, 1'b1);
        chk("resync_lsb", od_l, 8'h01);
        chk("resync_msb", od_m, 8'h80);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // reset mid-byte
        send_bits(8'hFF, 4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nvalid = 0;
        send_bits(8'h5A, 8, 1'b1);
        chk("rstmid_data", od_l, 8'h5A);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rstmid_once", 8'(nvalid), 8'h01);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 4),
                 ($urandom_range(0, 99) < 80),
                 1'($urandom),
                 ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 10));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule : tb_demux8_deser
`default_nettype wire

// File: doc/demux8_deser.md
# demux8_deser

Serial-to-parallel receiver: the receiving end of the team's 8:1 mux serializer path. It steers each accepted serial bit into one of eight byte positions through a 1:8 demux driven by a 3-bit bit counter, exactly inverting the mux ordering. Completed bytes are presented on a valid/ready output with a single holding register and overflow detection. It sits between a serial link, fed by the mux-based transmitter, and byte-wide consumers.

## Interface
- Parameters:
  - MSB_FIRST, default 0. When 0, the first accepted bit lands in D[0], so Sel=000 maps to A[0]. When 1, the first accepted bit lands in D[7].
- Ports:
  - clk  in  1  rising-edge clock
  - rst  in  1  reset, synchronous and active-high
  - bit_in  in  1  serial data bit
  - bit_valid  in  1  bit_in is accepted on this edge
  - frame_sync  in  1  restart the byte; the counter returns to 0
  - out_data  out  8  assembled byte, stable while out_valid=1
  - out_valid  out  1  holding register is full
  - out_ready  in  1  consumer accepts out_data this cycle
  - bit_idx  out  3  current write position (debug)
  - overflow  out  1  sticky: a completed byte was dropped
  - ovf_clear  in  1  clears overflow

## Operation
- Collect register col[7:0] and counter cnt[2:0].
- On each accepted bit, the demux write-enable one-hot selects pos = MSB_FIRST ? 7-cnt : cnt, and col[pos] <= bit_in.
- cnt increments modulo 8.
- On the 8th accepted bit (cnt==7 and bit_valid), the byte is complete. The completed byte is {col with the current bit merged}.
- Holding-state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY + byte complete: load out_data, go to FULL.
  - FULL + out_ready, no completion: go to EMPTY.
  - FULL + out_ready + completion: load the new byte, stay FULL. This gives zero bubbles.
  - FULL + !out_ready + completion: drop the new byte, set overflow. out_data is unchanged.
- frame_sync=1 forces cnt to 0 and discards the partial byte.
  - If bit_valid=1 in the same cycle, the bit is written as bit 0 of the new byte and cnt becomes 1.
  - frame_sync never affects the holding register.
- ovf_clear clears overflow. If a new drop occurs in the same cycle, set wins.
- col bits are not cleared between bytes. Every position is overwritten before the next completion.
- The reset value of every output is 0: out_data=8'h00, out_valid=0, bit_idx=0, overflow=0. cnt and col are also 0.
- Reset mid-byte or mid-hold discards all data. rst has priority over every other input.

## Timing
- Bit capture takes effect on the rising edge where bit_valid=1.
- Latency: out_valid rises on the same edge that captures the 8th bit, so the byte is visible in the following cycle.
- Handshake: transfer occurs on an edge where out_valid=1 and out_ready=1.
  - out_data and out_valid are held until that edge.
  - out_ready is ignored when out_valid=0.
- Continuous bit_valid=1 sustains one byte per 8 cycles with no gaps, provided out_ready keeps up.
- bit_valid=0 cycles freeze cnt and col.
- bit_idx equals cnt registered, with no extra delay.
- overflow sets on the edge of the dropping completion.
- No combinational path from inputs to outputs.

## Structure
- Shared package demux8_pkg holds:
  - BYTE_W=8 and SEL_W=3
  - hold-state enum {HOLD_EMPTY, HOLD_FULL}
- Sub-module demux1_8: purely combinational. Ports: Sel[2:0], D, en, and output Y[7:0], where Y[Sel]=D&en and all other outputs are 0.
  - The top instantiates it as the col write-enable decoder.
  - It is also reusable standalone as the inverse of the 8:1 mux.
- All sequential logic lives in demux8_deser.

## Test plan
- Reset check: rst high for 2 cycles, then low. Required: all outputs 0.
- LSB-first byte: MSB_FIRST=0, bits 1,0,1,0,0,1,0,1 on consecutive cycles, out_ready=1.
  - Required: out_data=8'hA5 and out_valid=1 in the cycle after the 8th bit.
  - out_valid drops one cycle later.
- MSB-first byte: MSB_FIRST=1, same bit sequence. Required: out_data=8'hA5 (bit reversal of LSB-first 0xA5 pattern yields 8'hA5). Then send 1,1,0,0,0,0,0,0. Required: 8'hC0.
- Back-to-back with stall: 16 continuous bits for 8'h3C then 8'hF0, out_ready=0 throughout.
  - Required: out_data=8'h3C is held and overflow=1 after bit 16.
  - Pulsing ovf_clear afterwards clears overflow.
- Resync: send 5 bits, then frame_sync=1 with bit_valid=1 carrying bit_in=1, then 7 more bits of 0.
  - Required: out_data=8'h01 and no partial data leaks.
- Reset mid-byte: 4 bits, then rst, then a full byte of 8'h5A.
  - Required: exactly one out_valid, with out_data=8'h5A.
